// File: rtl/saturn_decoder_pkg.sv
// Shared encodings for the Saturn instruction decoder: ALU op/register codes,
// decoder FSM states and a field-wrap helper.
package saturn_decoder_pkg;

  localparam logic [4:0] ALU_OP_ZERO     = 5'd1;
  localparam logic [4:0] ALU_OP_COPY     = 5'd2;
  localparam logic [4:0] ALU_OP_RST_BIT  = 5'd3;
  localparam logic [4:0] ALU_OP_SET_BIT  = 5'd4;
  localparam logic [4:0] ALU_OP_JMP_REL3 = 5'd5;
  localparam logic [4:0] ALU_OP_JMP_REL4 = 5'd6;
  localparam logic [4:0] ALU_OP_JMP_ABS5 = 5'd7;

  localparam logic [4:0] ALU_REG_NONE = 5'd0;
  localparam logic [4:0] ALU_REG_IMM  = 5'd1;
  localparam logic [4:0] ALU_REG_P    = 5'd2;
  localparam logic [4:0] ALU_REG_C    = 5'd3;
  localparam logic [4:0] ALU_REG_ST   = 5'd4;
  localparam logic [4:0] ALU_REG_D0   = 5'd5;
  localparam logic [4:0] ALU_REG_D1   = 5'd6;

  typedef enum logic [1:0] {
    DEC_ST_IDLE = 2'd0,
    DEC_ST_PFX1 = 2'd1,
    DEC_ST_PFX2 = 2'd2,
    DEC_ST_IMM  = 2'd3
  } dec_state_t;

  // Nibble-index arithmetic wraps modulo 16 (LC fields starting at P).
  function automatic logic [3:0] field_wrap(input logic [3:0] start, input logic [3:0] span);
    return start + span;
  endfunction

endpackage

// File: rtl/saturn_decoder_if.sv
// Decoder bus: fetch-side nibble inputs, ALU status inputs and ALU command outputs.
interface saturn_decoder_if;
  logic       i_en_dec;
  logic       i_en_alu_save;
  logic [3:0] i_nibble;
  logic       i_nibble_valid;
  logic       i_alu_stall_dec;
  logic [3:0] i_reg_p;
  logic       o_ins_decoded;
  logic       o_ins_alu_op;
  logic [4:0] o_alu_op;
  logic       o_alu_no_stall;
  logic [4:0] o_reg_dest;
  logic [4:0] o_reg_src1;
  logic [4:0] o_reg_src2;
  logic [3:0] o_field_start;
  logic [3:0] o_field_last;
  logic [3:0] o_imm_value;
  logic       o_decode_error;

  modport master (
    input  i_en_dec, i_en_alu_save, i_nibble, i_nibble_valid, i_alu_stall_dec, i_reg_p,
    output o_ins_decoded, o_ins_alu_op, o_alu_op, o_alu_no_stall, o_reg_dest,
           o_reg_src1, o_reg_src2, o_field_start, o_field_last, o_imm_value, o_decode_error
  );

  modport slave (
    output i_en_dec, i_en_alu_save, i_nibble, i_nibble_valid, i_alu_stall_dec, i_reg_p,
    input  o_ins_decoded, o_ins_alu_op, o_alu_op, o_alu_no_stall, o_reg_dest,
           o_reg_src1, o_reg_src2, o_field_start, o_field_last, o_imm_value, o_decode_error
  );
endinterface

// File: rtl/saturn_imm_buffer.sv
// Immediate nibble store: written by index during decode, read by the ALU step pointer.
module saturn_imm_buffer #(
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_data,
  input  logic [IDX_W-1:0] rd_ptr,
  output logic [3:0]       rd_data
);
  logic [3:0] mem [DEPTH];

  // Store one immediate nibble per accepted write; reset clears the whole buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 4'd0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/saturn_decoder.sv
// Saturn instruction decoder: walks opcode prefixes nibble by nibble, buffers the
// immediates and issues one registered ALU command per recognised instruction.
module saturn_decoder
  import saturn_decoder_pkg::*;
#(
  parameter int IMM_DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  saturn_decoder_if.master bus
);
  dec_state_t state;
  logic [3:0] first;
  logic [3:0] idx;
  logic [3:0] last_idx;
  logic [3:0] imm_last;
  logic [3:0] ptr;
  logic [4:0] pend_op;
  logic [4:0] pend_dest;
  logic [4:0] pend_src1;
  logic       pend_ns;
  logic       pend_lc;
  logic       accept;
  logic       wr_en;

  assign accept = bus.i_en_dec & bus.i_nibble_valid & ~bus.i_alu_stall_dec;
  assign wr_en  = accept & ((state == DEC_ST_PFX2) || (state == DEC_ST_IMM));
  assign bus.o_reg_src2 = ALU_REG_NONE;

  saturn_imm_buffer #(.DEPTH(IMM_DEPTH)) u_imm_buffer (
    .clk    (i_clk),
    .rst    (i_reset),
    .wr_en  (wr_en),
    .wr_idx (idx),
    .wr_data(bus.i_nibble),
    .rd_ptr (ptr),
    .rd_data(bus.o_imm_value)
  );

  // Decode FSM with registered ALU command outputs and immediate step pointer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state              <= DEC_ST_IDLE;
      first              <= 4'd0;
      idx                <= 4'd0;
      last_idx           <= 4'd0;
      imm_last           <= 4'd0;
      ptr                <= 4'd0;
      pend_op            <= 5'd0;
      pend_dest          <= ALU_REG_NONE;
      pend_src1          <= ALU_REG_NONE;
      pend_ns            <= 1'b0;
      pend_lc            <= 1'b0;
      bus.o_ins_decoded  <= 1'b0;
      bus.o_ins_alu_op   <= 1'b0;
      bus.o_alu_op       <= 5'd0;
      bus.o_alu_no_stall <= 1'b0;
      bus.o_reg_dest     <= ALU_REG_NONE;
      bus.o_reg_src1     <= ALU_REG_NONE;
      bus.o_field_start  <= 4'd0;
      bus.o_field_last   <= 4'd0;
      bus.o_decode_error <= 1'b0;
    end else begin
      bus.o_ins_decoded  <= 1'b0;
      bus.o_decode_error <= 1'b0;
      // The ALU walks the immediates one save phase at a time and parks on the last one.
      if (bus.i_en_alu_save && (ptr != imm_last)) ptr <= ptr + 4'd1;
      if (accept) begin
        unique case (state)
          DEC_ST_IDLE: begin
            first     <= bus.i_nibble;
            idx       <= 4'd0;
            pend_lc   <= 1'b0;
            pend_ns   <= 1'b0;
            pend_src1 <= ALU_REG_IMM;
            pend_dest <= ALU_REG_NONE;
            case (bus.i_nibble)
              4'h0, 4'h1, 4'h8: state <= DEC_ST_PFX1;
              4'h2: begin
                pend_op <= ALU_OP_COPY; pend_dest <= ALU_REG_P; pend_ns <= 1'b1;
                last_idx <= 4'd0; state <= DEC_ST_IMM;
              end
              4'h3: begin
                pend_op <= ALU_OP_COPY; pend_dest <= ALU_REG_C; pend_lc <= 1'b1;
                state <= DEC_ST_PFX1;
              end
              4'h6: begin
                pend_op <= ALU_OP_JMP_REL3; last_idx <= 4'd2; state <= DEC_ST_IMM;
              end
              default: bus.o_decode_error <= 1'b1;
            endcase
          end
          DEC_ST_PFX1: begin
            state <= DEC_ST_IMM;
            case (first)
              4'h0: begin
                state <= DEC_ST_IDLE;
                if (bus.i_nibble == 4'h8) begin
                  // CLRST has no immediates: issue the command right away.
                  bus.o_ins_decoded  <= 1'b1;
                  bus.o_ins_alu_op   <= 1'b1;
                  bus.o_alu_op       <= ALU_OP_ZERO;
                  bus.o_alu_no_stall <= 1'b0;
                  bus.o_reg_dest     <= ALU_REG_ST;
                  bus.o_reg_src1     <= ALU_REG_NONE;
                  bus.o_field_start  <= 4'd0;
                  bus.o_field_last   <= 4'd2;
                  imm_last           <= 4'd0;
                  ptr                <= 4'd0;
                end else begin
                  bus.o_decode_error <= 1'b1;
                end
              end
              4'h1: begin
                // Bit 2 of the second nibble selects D1 over D0.
                pend_op   <= ALU_OP_COPY;
                pend_dest <= bus.i_nibble[2] ? ALU_REG_D1 : ALU_REG_D0;
                case (bus.i_nibble)
                  4'h9, 4'hD: last_idx <= 4'd1;
                  4'hA, 4'hE: last_idx <= 4'd3;
                  4'hB, 4'hF: last_idx <= 4'd4;
                  default: begin bus.o_decode_error <= 1'b1; state <= DEC_ST_IDLE; end
                endcase
              end
              4'h3: last_idx <= bus.i_nibble;
              4'h8: begin
                case (bus.i_nibble)
                  4'h4, 4'h5: begin
                    pend_op   <= bus.i_nibble[0] ? ALU_OP_SET_BIT : ALU_OP_RST_BIT;
                    pend_dest <= ALU_REG_ST; pend_ns <= 1'b1;
                    last_idx  <= 4'd0; state <= DEC_ST_PFX2;
                  end
                  4'hC: begin pend_op <= ALU_OP_JMP_REL4; last_idx <= 4'd3; end
                  4'hD: begin pend_op <= ALU_OP_JMP_ABS5; last_idx <= 4'd4; end
                  default: begin bus.o_decode_error <= 1'b1; state <= DEC_ST_IDLE; end
                endcase
              end
              default: begin bus.o_decode_error <= 1'b1; state <= DEC_ST_IDLE; end
            endcase
          end
          DEC_ST_PFX2, DEC_ST_IMM: begin
            idx <= idx + 4'd1;
            if (idx == last_idx) begin
              bus.o_ins_decoded  <= 1'b1;
              bus.o_ins_alu_op   <= 1'b1;
              bus.o_alu_op       <= pend_op;
              bus.o_alu_no_stall <= pend_ns;
              bus.o_reg_dest     <= pend_dest;
              bus.o_reg_src1     <= pend_src1;
              bus.o_field_start  <= pend_lc ? bus.i_reg_p : 4'd0;
              bus.o_field_last   <= pend_lc ? field_wrap(bus.i_reg_p, last_idx) : last_idx;
              imm_last           <= last_idx;
              ptr                <= 4'd0;
              state              <= DEC_ST_IDLE;
            end
          end
          default: state <= DEC_ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_saturn_decoder.sv
// Bench for saturn_decoder: directed scenarios plus randomized instruction streams
// checked against an instruction-level reference model.
module tb_saturn_decoder;
  import saturn_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  saturn_decoder_if bus();

  saturn_decoder #(.IMM_DEPTH(16)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [3:0]  seq [20];
  int          m_len;
  int          m_k;
  bit          m_err;
  logic [4:0]  m_op, m_dest, m_src1;
  bit          m_ns;
  logic [3:0]  m_start, m_last;
  logic [3:0]  m_imm [16];
  logic [29:0] held;

  // {alu_op flag, op, no_stall, dest, src1, src2, start, last}
  function automatic logic [29:0] pk(input logic [4:0] op, input bit ns, input logic [4:0] dest,
                                     input logic [4:0] src1, input logic [3:0] s, input logic [3:0] l);
    return {1'b1, op, ns, dest, src1, 5'd0, s, l};
  endfunction

  function automatic logic [31:0] outs();
    return {bus.o_decode_error, bus.o_ins_decoded, bus.o_ins_alu_op, bus.o_alu_op,
            bus.o_alu_no_stall, bus.o_reg_dest, bus.o_reg_src1, bus.o_reg_src2,
            bus.o_field_start, bus.o_field_last};
  endfunction

  // Instruction-level model: what the nibble sequence in seq[] means for register P = p.
  task automatic model(input logic [3:0] p);
    int base;
    bit lc;
    m_err = 0; m_op = 5'd0; m_dest = ALU_REG_NONE; m_src1 = ALU_REG_IMM; m_ns = 0;
    m_k = 0; base = 1; lc = 0;
    case (seq[0])
      4'h2: begin m_op = ALU_OP_COPY; m_dest = ALU_REG_P; m_ns = 1; m_k = 1; end
      4'h3: begin m_op = ALU_OP_COPY; m_dest = ALU_REG_C; m_k = int'(seq[1]) + 1; base = 2; lc = 1; end
      4'h6: begin m_op = ALU_OP_JMP_REL3; m_k = 3; end
      4'h0: begin
        base = 2;
        if (seq[1] == 4'h8) begin m_op = ALU_OP_ZERO; m_dest = ALU_REG_ST; m_src1 = ALU_REG_NONE; end
        else m_err = 1;
      end
      4'h1: begin
        base = 2; m_op = ALU_OP_COPY;
        case (seq[1])
          4'h9: begin m_dest = ALU_REG_D0; m_k = 2; end
          4'hA: begin m_dest = ALU_REG_D0; m_k = 4; end
          4'hB: begin m_dest = ALU_REG_D0; m_k = 5; end
          4'hD: begin m_dest = ALU_REG_D1; m_k = 2; end
          4'hE: begin m_dest = ALU_REG_D1; m_k = 4; end
          4'hF: begin m_dest = ALU_REG_D1; m_k = 5; end
          default: m_err = 1;
        endcase
      end
      4'h8: begin
        base = 2;
        case (seq[1])
          4'h4: begin m_op = ALU_OP_RST_BIT; m_dest = ALU_REG_ST; m_ns = 1; m_k = 1; end
          4'h5: begin m_op = ALU_OP_SET_BIT; m_dest = ALU_REG_ST; m_ns = 1; m_k = 1; end
          4'hC: begin m_op = ALU_OP_JMP_REL4; m_k = 4; end
          4'hD: begin m_op = ALU_OP_JMP_ABS5; m_k = 5; end
          default: m_err = 1;
        endcase
      end
      default: m_err = 1;
    endcase
    m_len = m_err ? base : base + m_k;
    if (lc) begin
      m_start = p;
      m_last  = 4'((int'(p) + int'(seq[1])) % 16);
    end else if (m_op == ALU_OP_ZERO) begin
      m_start = 4'd0; m_last = 4'd2;
    end else begin
      m_start = 4'd0; m_last = 4'(m_k - 1);
    end
    for (int i = 0; i < m_k; i++) m_imm[i] = seq[base + i];
  endtask

  task automatic drive_nib(input logic [3:0] n);
    bus.i_en_dec = 1'b1; bus.i_nibble_valid = 1'b1; bus.i_nibble = n;
    @(posedge clk); #1;
    bus.i_en_dec = 1'b0; bus.i_nibble_valid = 1'b0;
  endtask

  task automatic save_pulse();
    bus.i_en_alu_save = 1'b1;
    @(posedge clk); #1;
    bus.i_en_alu_save = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({outs(), bus.o_imm_value} !== 36'd0) begin
      miscompares++; $display("FAIL reset_outputs: got %h want 0", {outs(), bus.o_imm_value});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (outs() !== 32'd0) begin
      miscompares++; $display("FAIL reset_release: got %h want 0", outs());
    end
  endtask

  task automatic test_p_eq();
    bus.i_reg_p = 4'h0;
    drive_nib(4'h2); drive_nib(4'h5);
    held = pk(ALU_OP_COPY, 1, ALU_REG_P, ALU_REG_IMM, 4'h0, 4'h0);
    vectors++;
    if (outs() !== {2'b01, held}) begin
      miscompares++; $display("FAIL p_eq_cmd: got %h want %h", outs(), {2'b01, held});
    end
    vectors++;
    if (bus.o_imm_value !== 4'h5) begin
      miscompares++; $display("FAIL p_eq_imm: got %h want 5", bus.o_imm_value);
    end
    @(posedge clk); #1;
    vectors++;
    if (outs() !== {2'b00, held}) begin
      miscompares++; $display("FAIL p_eq_pulse: got %h want %h", outs(), {2'b00, held});
    end
  endtask

  task automatic test_lc_wrap();
    logic [3:0] e [3] = '{4'hA, 4'hB, 4'hC};
    bus.i_reg_p = 4'hE;
    drive_nib(4'h3); drive_nib(4'h2); drive_nib(4'hA); drive_nib(4'hB); drive_nib(4'hC);
    held = pk(ALU_OP_COPY, 0, ALU_REG_C, ALU_REG_IMM, 4'hE, 4'h0);
    vectors++;
    if (outs() !== {2'b01, held}) begin
      miscompares++; $display("FAIL lc_cmd: got %h want %h", outs(), {2'b01, held});
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.o_imm_value !== e[i]) begin
        miscompares++; $display("FAIL lc_imm%0d: got %h want %h", i, bus.o_imm_value, e[i]);
      end
      save_pulse();
    end
    vectors++;
    if (bus.o_imm_value !== 4'hC) begin
      miscompares++; $display("FAIL lc_imm_hold: got %h want c", bus.o_imm_value);
    end
  endtask

  task automatic test_goto();
    drive_nib(4'h6); drive_nib(4'hF); drive_nib(4'hF); drive_nib(4'hF);
    held = pk(ALU_OP_JMP_REL3, 0, ALU_REG_NONE, ALU_REG_IMM, 4'h0, 4'h2);
    vectors++;
    if (outs() !== {2'b01, held}) begin
      miscompares++; $display("FAIL goto_cmd: got %h want %h", outs(), {2'b01, held});
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.o_imm_value !== 4'hF) begin
        miscompares++; $display("FAIL goto_imm%0d: got %h want f", i, bus.o_imm_value);
      end
      save_pulse();
    end
  endtask

  task automatic test_d1();
    drive_nib(4'h1); drive_nib(4'hF);
    for (int i = 1; i <= 5; i++) drive_nib(4'(i));
    held = pk(ALU_OP_COPY, 0, ALU_REG_D1, ALU_REG_IMM, 4'h0, 4'h4);
    vectors++;
    if (outs() !== {2'b01, held}) begin
      miscompares++; $display("FAIL d1_cmd: got %h want %h", outs(), {2'b01, held});
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.o_imm_value !== 4'(i + 1)) begin
        miscompares++; $display("FAIL d1_imm%0d: got %h want %h", i, bus.o_imm_value, 4'(i + 1));
      end
      save_pulse();
    end
  endtask

  task automatic test_stall();
    drive_nib(4'h2);
    bus.i_alu_stall_dec = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_nib(4'h9);
      vectors++;
      if (outs() !== {2'b00, held}) begin
        miscompares++; $display("FAIL stall_hold%0d: got %h want %h", i, outs(), {2'b00, held});
      end
    end
    bus.i_alu_stall_dec = 1'b0;
    drive_nib(4'h4);
    held = pk(ALU_OP_COPY, 1, ALU_REG_P, ALU_REG_IMM, 4'h0, 4'h0);
    vectors++;
    if ({outs(), bus.o_imm_value} !== {2'b01, held, 4'h4}) begin
      miscompares++; $display("FAIL stall_resume: got %h want %h", {outs(), bus.o_imm_value}, {2'b01, held, 4'h4});
    end
  endtask

  task automatic test_error();
    drive_nib(4'h8); drive_nib(4'h7);
    vectors++;
    if (outs() !== {2'b10, held}) begin
      miscompares++; $display("FAIL err_pulse: got %h want %h", outs(), {2'b10, held});
    end
    @(posedge clk); #1;
    vectors++;
    if (outs() !== {2'b00, held}) begin
      miscompares++; $display("FAIL err_clear: got %h want %h", outs(), {2'b00, held});
    end
    drive_nib(4'h2); drive_nib(4'h3);
    held = pk(ALU_OP_COPY, 1, ALU_REG_P, ALU_REG_IMM, 4'h0, 4'h0);
    vectors++;
    if ({outs(), bus.o_imm_value} !== {2'b01, held, 4'h3}) begin
      miscompares++; $display("FAIL err_recover: got %h want %h", {outs(), bus.o_imm_value}, {2'b01, held, 4'h3});
    end
  endtask

  task automatic test_reset_mid();
    drive_nib(4'h1); drive_nib(4'hA); drive_nib(4'h4);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({outs(), bus.o_imm_value} !== 36'd0) begin
      miscompares++; $display("FAIL reset_mid_async: got %h want 0", {outs(), bus.o_imm_value});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    drive_nib(4'h2); drive_nib(4'h1);
    held = pk(ALU_OP_COPY, 1, ALU_REG_P, ALU_REG_IMM, 4'h0, 4'h0);
    vectors++;
    if ({outs(), bus.o_imm_value} !== {2'b01, held, 4'h1}) begin
      miscompares++; $display("FAIL reset_mid_p1: got %h want %h", {outs(), bus.o_imm_value}, {2'b01, held, 4'h1});
    end
  endtask

  task automatic test_random();
    logic [3:0] p;
    logic [29:0] want;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 20; i++) seq[i] = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: seq[0] = 4'h2;
        1: seq[0] = 4'h3;
        2: seq[0] = 4'h6;
        3: begin seq[0] = 4'h0; seq[1] = 4'h8; end
        4: seq[0] = 4'h1;
        5: seq[0] = 4'h8;
        default: ;
      endcase
      p = 4'($urandom_range(0, 15));
      bus.i_reg_p = p;
      model(p);
      for (int i = 0; i < m_len; i++) begin
        // Cycles where the nibble must not be taken.
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          case ($urandom_range(0, 2))
            0: begin bus.i_en_dec = 1'b0; bus.i_nibble_valid = 1'b1; end
            1: begin bus.i_en_dec = 1'b1; bus.i_nibble_valid = 1'b0; end
            default: begin bus.i_en_dec = 1'b1; bus.i_nibble_valid = 1'b1; bus.i_alu_stall_dec = 1'b1; end
          endcase
          bus.i_nibble = 4'($urandom_range(0, 15));
          @(posedge clk); #1;
          bus.i_en_dec = 1'b0; bus.i_nibble_valid = 1'b0; bus.i_alu_stall_dec = 1'b0;
          vectors++;
          if (outs() !== {2'b00, held}) begin
            miscompares++; $display("FAIL rnd_gap n=%0d: got %h want %h", n, outs(), {2'b00, held});
          end
        end
        bus.i_en_alu_save = (i < m_len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        drive_nib(seq[i]);
        bus.i_en_alu_save = 1'b0;
      end
      if (m_err) begin
        vectors++;
        if (outs() !== {2'b10, held}) begin
          miscompares++; $display("FAIL rnd_err n=%0d: got %h want %h", n, outs(), {2'b10, held});
        end
      end else begin
        want = pk(m_op, m_ns, m_dest, m_src1, m_start, m_last);
        vectors++;
        if (outs() !== {2'b01, want}) begin
          miscompares++; $display("FAIL rnd_cmd n=%0d: got %h want %h", n, outs(), {2'b01, want});
        end
        held = want;
        for (int i = 0; i < m_k; i++) begin
          vectors++;
          if (bus.o_imm_value !== m_imm[i]) begin
            miscompares++; $display("FAIL rnd_imm n=%0d i=%0d: got %h want %h", n, i, bus.o_imm_value, m_imm[i]);
          end
          save_pulse();
        end
        if (m_k > 0) begin
          vectors++;
          if (bus.o_imm_value !== m_imm[m_k - 1]) begin
            miscompares++; $display("FAIL rnd_imm_hold n=%0d: got %h want %h", n, bus.o_imm_value, m_imm[m_k - 1]);
          end
        end
      end
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
        vectors++;
        if (outs() !== {2'b00, held}) begin
          miscompares++; $display("FAIL rnd_after n=%0d: got %h want %h", n, outs(), {2'b00, held});
        end
      end
    end
  endtask

  initial begin
    bus.i_en_dec = 1'b0; bus.i_en_alu_save = 1'b0; bus.i_nibble = 4'h0;
    bus.i_nibble_valid = 1'b0; bus.i_alu_stall_dec = 1'b0; bus.i_reg_p = 4'h0;
    held = 30'd0;
    test_reset();
    test_p_eq();
    test_lc_wrap();
    test_goto();
    test_d1();
    test_stall();
    test_error();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
